decode_buffer: RTL and testbench
================================

Name: decode_buffer

Overview:
- Parametrised decode-stage queue between fetch and execute.
- Each accepted instruction is decoded on entry: operand and destination fields, XLEN sign-extended immediate, op class, writeback and illegal flags.
- Decoded entries sit in a DEPTH-entry FIFO with valid/ready handshakes on both sides and a synchronous flush for branch redirect and traps.
- Replaces single-cycle combinational decode, so fetch and execute can stall independently.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- XLEN, 64, datapath width; 32 or 64 only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  buffer can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head.
- out_pc  out  XLEN  head PC.
- out_instr  out  32  head raw instruction.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_class  out  4  op class.
- out_wb  out  1  writes a non-zero rd.
- out_mul  out  1  M-extension op.
- out_illegal  out  1  illegal instruction.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers and count go to 0; all storage goes to 0.
  - Outputs: out_valid=0, in_ready=1, every payload output 0.
- Handshakes:
  - Enqueue fires when in_valid&&in_ready; dequeue fires when out_valid&&out_ready.
  - in_ready = (count!=DEPTH), from registered state only, with no path from out_ready.
  - out_valid = (count!=0).
- Latency: an entry enqueued in cycle N appears on out_* in cycle N+1 at the earliest. There is no bypass; an empty buffer never passes input straight to output.
- Full buffer: enqueue is refused even if a dequeue fires the same cycle; count drops by 1.
- Not full and not empty: simultaneous enqueue and dequeue leave count unchanged.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- Payload outputs always show the head slot, including stale data while out_valid=0.
- flush=1: next cycle count=0 and both pointers=0. Any enqueue or dequeue in the flush cycle is discarded. Storage is not cleared.
- Decode happens combinationally on in_instr before storage.
- out_class encoding:
  - 0 OP, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR.
  - 7 LUI, 8 AUIPC, 9 SYSTEM, 10 OP-32/OP-IMM-32.
  - 15 ILLEGAL.
- Immediate by format, sign-extended from the top instruction bit to XLEN:
  - I: OP-IMM, LOAD, JALR, OP-IMM-32.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC; value is imm<<12.
  - J: JAL.
  - SYSTEM: zero-extended instr[31:20].
  - All other classes: 0.
- out_rd is forced to 0 for STORE and BRANCH.
- out_wb=1 only when the class is 0,1,2,5,6,7,8,9 or 10 and rd!=0.
- Illegal when any of:
  - instr[1:0]!=2'b11;
  - the opcode is unlisted;
  - OP-32/OP-IMM-32 when XLEN==32;
  - M-extension encoding with the feature disabled.
- An illegal entry is still queued with class 15, wb=0, mul=0 and imm=0; the trap is raised downstream.
- Async reset mid-operation discards all entries immediately.

Optional Feature:
- Macro DECODE_BUFFER_RVM_EN.
- Defined: OP or OP-32 with funct7=0000001 decodes with out_mul=1, class 0 or 10, wb per rd. When XLEN==32, an OP-32 M-extension encoding is still illegal.
- Undefined: those encodings are illegal and out_mul is tied to 0.

Test Plan:
- Reset, then 0xfff00093 enqueued -> next cycle out_valid=1, class=1, rd=1, rs1=0, imm=all ones, wb=1, illegal=0.
- DEPTH=4, out_ready=0, five back-to-back in_valid -> in_ready=0 after the 4th accept, count=4, 5th held. Then out_ready=1 with in_valid=1 while full -> count=3, no enqueue that cycle.
- 12 instructions with PCs 0x0,0x4,...,0x2c and random out_ready stalls -> out_pc sequence is in order with no loss or duplication across pointer wrap.
- count=3 with flush=1 and in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; the flushed-cycle input never appears.
- Decode checks:
  - 0x00112423 -> class=3, rd=0, rs1=2, rs2=1, imm=8, wb=0.
  - 0x022081B3 -> with macro: mul=1, class=0, rd=3, wb=1; without macro: class=15, illegal=1.
  - 0x00000000 -> illegal=1.
- reset pulsed low for half a cycle with count=2 -> count=0 and out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_buffer.sv
// decode_buffer: decode-on-entry FIFO between fetch and execute.
// Optional M-extension decode is enabled by defining DECODE_BUFFER_RVM_EN.
module decode_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [XLEN-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [31:0]                  out_instr,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [4:0]                   out_rd,
  output logic [XLEN-1:0]              out_imm,
  output logic [3:0]                   out_class,
  output logic                         out_wb,
  output logic                         out_mul,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      cls;
    logic            wb;
    logic            mul;
    logic            ill;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          dec;
  ent_t          head;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_enq, do_deq;

  logic [6:0]  opc;
  logic        is_op, is_opi, is_ld, is_st;
  logic        is_br, is_jal, is_jalr, is_lui;
  logic        is_auipc, is_sys, is_op32, is_opi32;
  logic        m_enc, legal;
  logic [3:0]  cls;
  logic [4:0]  rd;
  logic [31:0] imm32;
  logic [31:0] i_imm, s_imm, b_imm;
  logic [31:0] u_imm, j_imm, z_imm;

  assign opc      = in_instr[6:0];
  assign is_op    = opc == 7'b0110011;
  assign is_opi   = opc == 7'b0010011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_br    = opc == 7'b1100011;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_sys   = opc == 7'b1110011;
  assign is_op32  = opc == 7'b0111011;
  assign is_opi32 = opc == 7'b0011011;
  assign m_enc    = (is_op || is_op32) &&
                    in_instr[31:25] == 7'b0000001;

  assign i_imm = {{20{in_instr[31]}}, in_instr[31:20]};
  assign s_imm = {{20{in_instr[31]}}, in_instr[31:25],
                  in_instr[11:7]};
  assign b_imm = {{19{in_instr[31]}}, in_instr[31],
                  in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign u_imm = {in_instr[31:12], 12'b0};
  assign j_imm = {{11{in_instr[31]}}, in_instr[31],
                  in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
  assign z_imm = {20'b0, in_instr[31:20]};
  assign rd    = (is_st || is_br) ? 5'd0 : in_instr[11:7];

  always_comb begin
    cls   = 4'd15;
    imm32 = '0;
    legal = 1'b1;
    unique case (1'b1)
      is_op:    cls = 4'd0;
      is_opi:   begin cls = 4'd1;  imm32 = i_imm; end
      is_ld:    begin cls = 4'd2;  imm32 = i_imm; end
      is_st:    begin cls = 4'd3;  imm32 = s_imm; end
      is_br:    begin cls = 4'd4;  imm32 = b_imm; end
      is_jal:   begin cls = 4'd5;  imm32 = j_imm; end
      is_jalr:  begin cls = 4'd6;  imm32 = i_imm; end
      is_lui:   begin cls = 4'd7;  imm32 = u_imm; end
      is_auipc: begin cls = 4'd8;  imm32 = u_imm; end
      is_sys:   begin cls = 4'd9;  imm32 = z_imm; end
      is_op32:  cls = 4'd10;
      is_opi32: begin cls = 4'd10; imm32 = i_imm; end
      default:  legal = 1'b0;
    endcase
    if (in_instr[1:0] != 2'b11)
      legal = 1'b0;
    if ((is_op32 || is_opi32) && XLEN == 32)
      legal = 1'b0;
`ifndef DECODE_BUFFER_RVM_EN
    if (m_enc)
      legal = 1'b0;
`endif
    dec       = '0;
    dec.pc    = in_pc;
    dec.instr = in_instr;
    dec.rs1   = in_instr[19:15];
    dec.rs2   = in_instr[24:20];
    dec.rd    = rd;
    dec.cls   = 4'd15;
    dec.ill   = !legal;
    if (legal) begin
      dec.cls = cls;
      dec.imm = XLEN'($signed(imm32));
      // STORE/BRANCH already have rd forced to 0
      dec.wb  = rd != 5'd0;
`ifdef DECODE_BUFFER_RVM_EN
      dec.mul = m_enc;
`endif
    end
  end

  assign in_ready  = cnt_q != CW'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign do_enq    = in_valid && in_ready;
  assign do_deq    = out_valid && out_ready;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_enq)
        wptr_d = wptr_q + PW'(1);
      if (do_deq)
        rptr_d = rptr_q + PW'(1);
      if (do_enq && !do_deq)
        cnt_d = cnt_q + CW'(1);
      else if (!do_enq && do_deq)
        cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int k = 0; k < DEPTH; k++)
        mem_q[k] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_enq && !flush)
        mem_q[wptr_q] <= dec;
    end
  end

  assign head        = mem_q[rptr_q];
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_imm     = head.imm;
  assign out_class   = head.cls;
  assign out_wb      = head.wb;
  assign out_mul     = head.mul;
  assign out_illegal = head.ill;
  assign count       = cnt_q;

endmodule

// File: tb/tb_decode_buffer.sv
// tb_decode_buffer: decode table plus scoreboarded FIFO sequences.
// Build with or without DECODE_BUFFER_RVM_EN to match the DUT.
module tb_decode_buffer;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        wb;
    logic        mul;
    logic        ill;
    logic        regs;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [63:0] pc;
  } sb_t;

  localparam int NV = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [63:0] out_imm;
  logic [3:0]  out_class;
  logic        out_wb, out_mul, out_illegal;
  logic [2:0]  count;

  vec_t vt [NV];
  vec_t cur_v;
  sb_t  sbq [$];
  sb_t  e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;

  decode_buffer #(.DEPTH(4), .XLEN(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_class(out_class),
    .out_wb(out_wb), .out_mul(out_mul),
    .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int idx, logic [63:0] pc);
    in_instr = vt[idx].instr;
    in_pc    = pc;
    cur_v    = vt[idx];
    in_valid = 1'b1;
  endtask

  // Handshakes are predicted at negedge for the following posedge.
  always @(negedge clk) begin
    if (reset) begin
      if (flush) begin
        sbq.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_pop++;
          if (sbq.size() == 0) begin
            chk("sb_unexpected_pop", out_pc, 64'hDEAD);
          end else begin
            e = sbq.pop_front();
            chk("sb_pc", out_pc, e.pc);
            chk("sb_instr", 64'(out_instr), 64'(e.v.instr));
            chk("sb_class", 64'(out_class), 64'(e.v.cls));
            chk("sb_imm", out_imm, e.v.imm);
            chk("sb_wb", 64'(out_wb), 64'(e.v.wb));
            chk("sb_mul", 64'(out_mul), 64'(e.v.mul));
            chk("sb_ill", 64'(out_illegal), 64'(e.v.ill));
            if (e.v.regs) begin
              chk("sb_rd", 64'(out_rd), 64'(e.v.rd));
              chk("sb_rs1", 64'(out_rs1), 64'(e.v.rs1));
              chk("sb_rs2", 64'(out_rs2), 64'(e.v.rs2));
            end
          end
        end
        if (in_valid && in_ready)
          sbq.push_back('{v: cur_v, pc: in_pc});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int guard;
    int i;
    logic acc;
    int pops0;
    vt[0]  = '{32'hfff00093, 4'd1, 5'd1, 5'd0, 5'd31,
               64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 1};
    vt[1]  = '{32'h00112423, 4'd3, 5'd0, 5'd2, 5'd1,
               64'd8, 0, 0, 0, 1};
`ifdef DECODE_BUFFER_RVM_EN
    vt[2]  = '{32'h022081B3, 4'd0, 5'd3, 5'd1, 5'd2,
               64'd0, 1, 1, 0, 1};
`else
    vt[2]  = '{32'h022081B3, 4'd15, 5'd3, 5'd1, 5'd2,
               64'd0, 0, 0, 1, 0};
`endif
    vt[3]  = '{32'h00000000, 4'd15, 5'd0, 5'd0, 5'd0,
               64'd0, 0, 0, 1, 0};
    vt[4]  = '{32'h800000B7, 4'd7, 5'd1, 5'd0, 5'd0,
               64'hFFFF_FFFF_8000_0000, 1, 0, 0, 1};
    vt[5]  = '{32'hFE000EE3, 4'd4, 5'd0, 5'd0, 5'd0,
               64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 1};
    vt[6]  = '{32'h001000EF, 4'd5, 5'd1, 5'd0, 5'd1,
               64'h800, 1, 0, 0, 1};
    vt[7]  = '{32'hFFF08067, 4'd6, 5'd0, 5'd1, 5'd31,
               64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1};
    vt[8]  = '{32'hFFF022F3, 4'd9, 5'd5, 5'd0, 5'd31,
               64'hFFF, 1, 0, 0, 1};
    vt[9]  = '{32'hFFE0811B, 4'd10, 5'd2, 5'd1, 5'd30,
               64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 1};
    vt[10] = '{32'h00000001, 4'd15, 5'd0, 5'd0, 5'd0,
               64'd0, 0, 0, 1, 0};
    vt[11] = '{32'h0000007F, 4'd15, 5'd0, 5'd0, 5'd0,
               64'd0, 0, 0, 1, 0};
    vt[12] = '{32'h002081B3, 4'd0, 5'd3, 5'd1, 5'd2,
               64'd0, 1, 0, 0, 1};
    vt[13] = '{32'hFF812203, 4'd2, 5'd4, 5'd2, 5'd24,
               64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 0, 1};
    vt[14] = '{32'h00001397, 4'd8, 5'd7, 5'd0, 5'd0,
               64'h1000, 1, 0, 0, 1};
    cur_v = vt[0];

    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_imm", out_imm, 64'd0);
    reset = 1'b1;
    step();

    for (int k = 0; k < NV; k++) begin
      drive(k, 64'(k * 4));
      out_ready = 1'b0;
      if (k == 0)
        chk("no_bypass", 64'(out_valid), 64'd0);
      step();
      in_valid = 1'b0;
      chk("tbl_valid", 64'(out_valid), 64'd1);
      chk("tbl_class", 64'(out_class), 64'(vt[k].cls));
      chk("tbl_imm", out_imm, vt[k].imm);
      chk("tbl_ill", 64'(out_illegal), 64'(vt[k].ill));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("tbl_drain", 64'(count), 64'd0);
    end

    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(k, 64'h100 + 64'(k * 4));
      step();
      chk("full_count", 64'(count), 64'(k < 4 ? k + 1 : 4));
      if (k == 3)
        chk("full_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("full_deq_count", 64'(count), 64'd3);
    guard = 0;
    while (count != 0 && guard < 20) begin
      step();
      guard++;
    end
    out_ready = 1'b0;
    chk("full_drained", 64'(count), 64'd0);

    pops0 = n_pop;
    i = 0;
    guard = 0;
    while ((i < 12 || count != 0) && guard < 500) begin
      out_ready = 1'($urandom_range(0, 1));
      if (i < 12)
        drive(i % NV, 64'(i * 4));
      else
        in_valid = 1'b0;
      acc = in_valid && in_ready;
      step();
      if (acc)
        i++;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("wrap_pops", 64'(n_pop - pops0), 64'd12);
    chk("wrap_sb_empty", 64'(sbq.size()), 64'd0);

    for (int k = 0; k < 3; k++) begin
      drive(k + 4, 64'h200 + 64'(k * 4));
      step();
    end
    chk("pre_flush_count", 64'(count), 64'd3);
    drive(12, 64'h300);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    drive(13, 64'h400);
    step();
    in_valid = 1'b0;
    chk("post_flush_pc", out_pc, 64'h400);
    step();
    chk("post_flush_empty", 64'(count), 64'd0);
    out_ready = 1'b0;

    for (int k = 0; k < 2; k++) begin
      drive(k + 6, 64'h500 + 64'(k * 4));
      step();
    end
    in_valid = 1'b0;
    chk("pre_areset_count", 64'(count), 64'd2);
    #3;
    reset = 1'b0;
    #1;
    chk("areset_count", 64'(count), 64'd0);
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_in_ready", 64'(in_ready), 64'd1);
    chk("areset_out_pc", out_pc, 64'd0);
    sbq.delete();
    #3;
    reset = 1'b1;
    step();
    drive(8, 64'h600);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("after_areset_count", 64'(count), 64'd0);
    chk("final_sb_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
